// File: rtl/multi_bcd_counter.sv
// Cascadable multi-digit BCD up/down counter with sync clear/load, wrap or saturate.
// Latency: one clock from step to DataOut; Cout is combinational; no backpressure.
module multi_bcd_counter #(
  parameter int DIGITS    = 4,
  parameter int WRAP      = 1,
  parameter int EDGE_MODE = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Trigger,
  input  logic                  Cin,
  input  logic                  Up,
  input  logic                  Clear,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadData,
  output logic [4*DIGITS-1:0]   DataOut,
  output logic                  Cout
);

  localparam bit SATURATE = (WRAP == 0);
  localparam bit EDGE     = (EDGE_MODE != 0);

  logic                trigger_d;
  logic                trig_q;
  logic                step;
  logic                terminal;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;

  assign trig_q = EDGE ? (Trigger & ~trigger_d) : Trigger;
  assign step   = trig_q | Cin;

  // A digit moves only when every lower digit sits at its rollover value;
  // the running AND of that condition across all digits is the terminal count.
  always_comb begin
    logic       lower_all;
    logic [3:0] digit;
    logic [3:0] nib;
    lower_all = 1'b1;
    digit     = '0;
    nib       = '0;
    stepped   = '0;
    loaded    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = DataOut[4*k +: 4];
      if (!lower_all) begin
        stepped[4*k +: 4] = digit;
      end else if (Up) begin
        stepped[4*k +: 4] = (digit >= 4'd9) ? 4'd0 : 4'(digit + 4'd1);
      end else begin
        stepped[4*k +: 4] = (digit == 4'd0) ? 4'd9 : 4'(digit - 4'd1);
      end
      lower_all = lower_all & (digit == (Up ? 4'd9 : 4'd0));
      nib = LoadData[4*k +: 4];
      loaded[4*k +: 4] = (nib > 4'd9) ? 4'd0 : nib;
    end
    terminal = lower_all;
  end

  assign Cout = Reset & step & terminal & ~Clear & ~Load;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      DataOut   <= '0;
      trigger_d <= 1'b0;
    end else begin
      trigger_d <= Trigger;
      if (Clear) begin
        DataOut <= '0;
      end else if (Load) begin
        DataOut <= loaded;
      end else if (step && !(terminal && SATURATE)) begin
        DataOut <= stepped;
      end
    end
  end

endmodule

// File: tb/tb_multi_bcd_counter.sv
// Three counter variants driven by shared stimulus, each checked every cycle
// against a decimal-integer model, plus literal spot checks of key sequences.
module tb_multi_bcd_counter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Trigger = 1'b0;
  logic        Cin = 1'b0;
  logic        Up = 1'b1;
  logic        Clear = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] LoadData = '0;

  logic [7:0]  dout_a, dout_b;
  logic [15:0] dout_c;
  logic        cout_a, cout_b, cout_c;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  multi_bcd_counter #(.DIGITS(2), .WRAP(1), .EDGE_MODE(0)) dut_a (
    .Clk(Clk), .Reset(Reset), .Trigger(Trigger), .Cin(Cin), .Up(Up),
    .Clear(Clear), .Load(Load), .LoadData(LoadData[7:0]),
    .DataOut(dout_a), .Cout(cout_a));

  multi_bcd_counter #(.DIGITS(2), .WRAP(0), .EDGE_MODE(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .Trigger(Trigger), .Cin(Cin), .Up(Up),
    .Clear(Clear), .Load(Load), .LoadData(LoadData[7:0]),
    .DataOut(dout_b), .Cout(cout_b));

  multi_bcd_counter #(.DIGITS(4), .WRAP(1), .EDGE_MODE(1)) dut_c (
    .Clk(Clk), .Reset(Reset), .Trigger(Trigger), .Cin(Cin), .Up(Up),
    .Clear(Clear), .Load(Load), .LoadData(LoadData),
    .DataOut(dout_c), .Cout(cout_c));

  // Model: each counter is a plain decimal integer.
  int nd[3]   = '{2, 2, 4};
  bit wr[3]   = '{1'b1, 1'b0, 1'b1};
  bit edg[3]  = '{1'b0, 1'b0, 1'b1};
  int mval[3] = '{0, 0, 0};
  bit trig_d_m = 1'b0;

  function automatic int maxv(int n);
    return (10 ** n) - 1;
  endfunction

  function automatic int load_val(logic [15:0] ld, int n);
    int v = 0;
    int w = 1;
    for (int k = 0; k < n; k++) begin
      int nibble = int'((ld >> (4 * k)) & 16'hF);
      v += ((nibble <= 9) ? nibble : 0) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int n);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < n; k++) begin
      r |= 32'(x % 10) << (4 * k);
      x /= 10;
    end
    return r;
  endfunction

  function automatic bit step_m(int i);
    return Cin | (edg[i] ? (Trigger & ~trig_d_m) : Trigger);
  endfunction

  function automatic bit cout_m(int i);
    return Reset & step_m(i) & ~Clear & ~Load & (mval[i] == (Up ? maxv(nd[i]) : 0));
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) mval[i] = 0;
      trig_d_m = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (Clear) mval[i] = 0;
        else if (Load) mval[i] = load_val(LoadData, nd[i]);
        else if (step_m(i)) begin
          if (Up) mval[i] = (mval[i] == maxv(nd[i])) ? (wr[i] ? 0 : mval[i]) : mval[i] + 1;
          else    mval[i] = (mval[i] == 0) ? (wr[i] ? maxv(nd[i]) : 0) : mval[i] - 1;
        end
      end
      trig_d_m = Trigger;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_out(int i);
    case (i)
      0:       return {24'b0, dout_a};
      1:       return {24'b0, dout_b};
      default: return {16'b0, dout_c};
    endcase
  endfunction

  function automatic logic dut_cout(int i);
    case (i)
      0:       return cout_a;
      1:       return cout_b;
      default: return cout_c;
    endcase
  endfunction

  always @(negedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_dout%0d", i), dut_out(i), to_bcd(mval[i], nd[i]));
      chk($sformatf("model_cout%0d", i), {31'b0, dut_cout(i)}, {31'b0, cout_m(i)});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  initial begin
    // Reset held with requests asserted: all must be ignored.
    Trigger = 1'b1; Load = 1'b1; LoadData = 16'h1234; Cin = 1'b1;
    tick(3);
    chk("reset_dout_a", {24'b0, dout_a}, 32'h0);
    chk("reset_dout_c", {16'b0, dout_c}, 32'h0);
    chk("reset_cout_a", {31'b0, cout_a}, 32'h0);
    Trigger = 1'b0; Load = 1'b0; Cin = 1'b0;
    Reset = 1'b1;
    tick(1);
    chk("release_idle", {24'b0, dout_a}, 32'h0);

    // Level-sensitive count 00..99 then wrap; saturating copy holds at 99.
    Up = 1'b1; Trigger = 1'b1;
    tick(1);
    chk("cnt_01", {24'b0, dout_a}, 32'h01);
    tick(56);
    chk("cnt_57", {24'b0, dout_a}, 32'h57);
    chk("cnt_57_cout", {31'b0, cout_a}, 32'h0);
    tick(42);
    chk("cnt_99", {24'b0, dout_a}, 32'h99);
    chk("cnt_99_cout", {31'b0, cout_a}, 32'h1);
    tick(1);
    chk("cnt_wrap_00", {24'b0, dout_a}, 32'h00);
    chk("sat_hold_99", {24'b0, dout_b}, 32'h99);
    chk("edge_one_step", {16'b0, dout_c}, 32'h0001);
    Trigger = 1'b0;

    // Load 49 then count down through the tens boundary.
    Load = 1'b1; LoadData = 16'h0049;
    tick(1);
    Load = 1'b0; Up = 1'b0; Cin = 1'b1;
    tick(1);
    chk("dn_48", {24'b0, dout_a}, 32'h48);
    tick(8);
    chk("dn_40", {24'b0, dout_a}, 32'h40);
    tick(1);
    chk("dn_39", {24'b0, dout_a}, 32'h39);
    Cin = 1'b0; Clear = 1'b1;
    tick(1);
    Clear = 1'b0; Cin = 1'b1;
    #1 chk("dn_00_cout", {31'b0, cout_a}, 32'h1);
    tick(1);
    chk("dn_wrap_99", {24'b0, dout_a}, 32'h99);
    chk("dn_sat_00", {24'b0, dout_b}, 32'h00);
    chk("dn_wrap_9999", {16'b0, dout_c}, 32'h9999);

    // Saturation at 99 with Cout each cycle, then one step down.
    Cin = 1'b0; Load = 1'b1; LoadData = 16'h0099;
    tick(1);
    Load = 1'b0; Up = 1'b1; Cin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("sat_cout", {31'b0, cout_b}, 32'h1);
      tick(1);
      chk("sat_stay_99", {24'b0, dout_b}, 32'h99);
    end
    Up = 1'b0;
    tick(1);
    chk("sat_down_98", {24'b0, dout_b}, 32'h98);
    Cin = 1'b0;

    // Edge mode: high 5, low 1, high 2 gives two steps; Trigger+Cin gives one.
    Clear = 1'b1; Up = 1'b1;
    tick(1);
    Clear = 1'b0; Trigger = 1'b1;
    tick(5);
    Trigger = 1'b0;
    tick(1);
    Trigger = 1'b1;
    tick(2);
    chk("edge_two_steps", {16'b0, dout_c}, 32'h0002);
    Trigger = 1'b0;
    tick(1);
    Trigger = 1'b1; Cin = 1'b1;
    tick(1);
    chk("trig_cin_one", {16'b0, dout_c}, 32'h0003);
    Trigger = 1'b0; Cin = 1'b0;

    // Clear beats Load; invalid nibble loads as zero; Load beats Step.
    Clear = 1'b1; Load = 1'b1; LoadData = 16'h0037;
    tick(1);
    chk("clr_over_load", {24'b0, dout_a}, 32'h00);
    Clear = 1'b0; LoadData = 16'h00A5;
    tick(1);
    chk("load_bad_nib", {24'b0, dout_a}, 32'h05);
    LoadData = 16'h0099; Trigger = 1'b1;
    #1 chk("load_step_cout", {31'b0, cout_a}, 32'h0);
    tick(1);
    chk("load_over_step", {24'b0, dout_a}, 32'h99);
    Load = 1'b0; Trigger = 1'b0;

    // Async reset between edges at 57, then count from zero.
    Load = 1'b1; LoadData = 16'h0056;
    tick(1);
    Load = 1'b0; Trigger = 1'b1;
    tick(1);
    chk("pre_rst_57", {24'b0, dout_a}, 32'h57);
    Reset = 1'b0;
    #1 chk("async_rst_00", {24'b0, dout_a}, 32'h00);
    chk("async_rst_cout", {31'b0, cout_a}, 32'h0);
    tick(1);
    Reset = 1'b1;
    tick(1);
    chk("post_rst_01", {24'b0, dout_a}, 32'h01);
    chk("post_rst_c", {16'b0, dout_c}, 32'h0001);

    // Randomized traffic, including occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      Trigger  = ($urandom_range(1, 0) == 1);
      Cin      = ($urandom_range(3, 0) == 0);
      if ($urandom_range(15, 0) == 0) Up = ~Up;
      Clear    = ($urandom_range(31, 0) == 0);
      Load     = ($urandom_range(15, 0) == 0);
      LoadData = 16'($urandom);
      Reset    = ($urandom_range(127, 0) != 0);
      tick(1);
    end
    Reset = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
